// File: rtl/fifo_pkg.sv
// Shared types, mode constants and elaboration helpers for the parametrised FIFO.
package fifo_pkg;

  localparam int FIFO_MODE_REG  = 0;
  localparam int FIFO_MODE_FWFT = 1;

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
    logic overflow;
    logic underflow;
  } fifo_status_t;

  // ceil(log2(v)); returns 0 for v <= 1
  function automatic int clog2(input int unsigned v);
    int unsigned x;
    int r;
    r = 0;
    x = (v > 0) ? v - 1 : 0;
    while (x > 0) begin
      r++;
      x = x >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// DEPTH x WIDTH storage: one synchronous write port, one asynchronous read port, no reset.
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with registered or first-word-fall-through read, registered
// occupancy flags, programmable thresholds and sticky overflow/underflow flags.
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter  int WIDTH     = 8,
  parameter  int DEPTH     = 16,
  parameter  int FWFT      = FIFO_MODE_REG,
  parameter  int AF_THRESH = DEPTH - 2,
  parameter  int AE_THRESH = 1,
  localparam int CW        = clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [CW-1:0]    count,
  output logic             overflow,
  output logic             underflow,
  input  logic             clr_err
);

  localparam int AW = clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("sync_fifo_param: DEPTH must be a power of two >= 2");
  end
  if (AF_THRESH > DEPTH) begin : g_bad_af
    $error("sync_fifo_param: AF_THRESH must not exceed DEPTH");
  end
  if (AE_THRESH >= DEPTH) begin : g_bad_ae
    $error("sync_fifo_param: AE_THRESH must be below DEPTH");
  end

  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    cnt, cnt_nx;
  fifo_status_t     st, st_nx;
  logic             push_acc, pop_acc;
  logic [WIDTH-1:0] head;

  fifo_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk   (clk),
    .we    (push_acc),
    .waddr (wr_ptr),
    .wdata (wr_data),
    .raddr (rd_ptr),
    .rdata (head)
  );

  // Flags are computed from the next count so they land together with it.
  always_comb begin
    push_acc           = rst_n && wr_en && !st.full;
    pop_acc            = rst_n && rd_en && !st.empty;
    cnt_nx             = cnt + CW'(push_acc) - CW'(pop_acc);
    st_nx              = st;
    st_nx.full         = (cnt_nx == DEPTH_C);
    st_nx.empty        = (cnt_nx == '0);
    st_nx.almost_full  = (cnt_nx >= AF_C);
    st_nx.almost_empty = (cnt_nx <= AE_C);
    st_nx.overflow     = (wr_en && st.full)  || (st.overflow  && !clr_err);
    st_nx.underflow    = (rd_en && st.empty) || (st.underflow && !clr_err);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      st     <= '{full: 1'b0, empty: 1'b1, almost_full: 1'b0,
                  almost_empty: 1'b1, overflow: 1'b0, underflow: 1'b0};
    end else begin
      if (push_acc) wr_ptr <= wr_ptr + 1'b1;
      if (pop_acc)  rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt_nx;
      st  <= st_nx;
    end
  end

  if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
    assign rd_data  = st.empty ? '0 : head;
    assign rd_valid = !st.empty;
  end else begin : g_reg
    logic [WIDTH-1:0] rd_q;
    logic             rd_v;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        rd_q <= '0;
        rd_v <= 1'b0;
      end else begin
        rd_v <= pop_acc;
        if (pop_acc) rd_q <= head;
      end
    end

    assign rd_data  = rd_q;
    assign rd_valid = rd_v;
  end

  assign count        = cnt;
  assign full         = st.full;
  assign empty        = st.empty;
  assign almost_full  = st.almost_full;
  assign almost_empty = st.almost_empty;
  assign overflow     = st.overflow;
  assign underflow    = st.underflow;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Drives a registered-read and an FWFT instance with identical stimulus and
// compares both against a queue-based reference model.
module tb_sync_fifo_param;

  localparam int W  = 8;
  localparam int D  = 4;
  localparam int CW = 3;
  localparam int AF = 2;
  localparam int AE = 1;

  logic          clk = 1'b0;
  logic          rst_n, wr_en, rd_en, clr_err;
  logic [W-1:0]  wr_data;

  logic [W-1:0]  r_rd_data, f_rd_data;
  logic          r_rd_valid, f_rd_valid;
  logic          r_full, r_empty, r_af, r_ae, r_ovf, r_udf;
  logic          f_full, f_empty, f_af, f_ae, f_ovf, f_udf;
  logic [CW-1:0] r_count, f_count;

  sync_fifo_param #(.WIDTH(W), .DEPTH(D), .FWFT(0), .AF_THRESH(AF), .AE_THRESH(AE)) u_reg (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(r_rd_data), .rd_valid(r_rd_valid), .full(r_full), .empty(r_empty),
    .almost_full(r_af), .almost_empty(r_ae), .count(r_count),
    .overflow(r_ovf), .underflow(r_udf), .clr_err(clr_err)
  );

  sync_fifo_param #(.WIDTH(W), .DEPTH(D), .FWFT(1), .AF_THRESH(AF), .AE_THRESH(AE)) u_fwft (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(f_rd_data), .rd_valid(f_rd_valid), .full(f_full), .empty(f_empty),
    .almost_full(f_af), .almost_empty(f_ae), .count(f_count),
    .overflow(f_ovf), .underflow(f_udf), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  logic [W-1:0] q[$];
  bit           m_ovf, m_udf, m_rdv;
  logic [W-1:0] m_rdq;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // One clock: drive inputs, advance the model, then compare both instances.
  task automatic step(input bit rst, input bit we, input logic [W-1:0] wd,
                      input bit re, input bit ce);
    bit push, pop;
    int unsigned n;
    rst_n   = !rst;
    wr_en   = we;
    wr_data = wd;
    rd_en   = re;
    clr_err = ce;
    @(posedge clk);
    if (rst) begin
      q.delete();
      m_ovf = 0; m_udf = 0; m_rdv = 0; m_rdq = '0;
    end else begin
      n     = q.size();
      push  = we && (n != D);
      pop   = re && (n != 0);
      m_ovf = (we && n == D) || (m_ovf && !ce);
      m_udf = (re && n == 0) || (m_udf && !ce);
      m_rdv = pop;
      if (pop)  m_rdq = q.pop_front();
      if (push) q.push_back(wd);
    end
    #1;
    n = q.size();
    check("r_count", 32'(r_count), n);
    check("r_full",  r_full,  n == D);
    check("r_empty", r_empty, n == 0);
    check("r_af",    r_af,    n >= AF);
    check("r_ae",    r_ae,    n <= AE);
    check("r_ovf",   r_ovf,   m_ovf);
    check("r_udf",   r_udf,   m_udf);
    check("r_rd_valid", r_rd_valid, m_rdv);
    check("r_rd_data",  r_rd_data,  m_rdq);
    check("f_count", 32'(f_count), n);
    check("f_full",  f_full,  n == D);
    check("f_empty", f_empty, n == 0);
    check("f_af",    f_af,    n >= AF);
    check("f_ae",    f_ae,    n <= AE);
    check("f_ovf",   f_ovf,   m_ovf);
    check("f_udf",   f_udf,   m_udf);
    check("f_rd_valid", f_rd_valid, n != 0);
    if (n != 0) check("f_rd_data", f_rd_data, q[0]);
  endtask

  initial begin
    logic [W-1:0] vals [4];
    vals = '{8'h11, 8'h22, 8'h33, 8'h44};

    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    check("rst_rd_data", r_rd_data, 0);
    check("rst_empty", r_empty, 1);

    // Fill to full, then overflow
    for (int i = 0; i < 4; i++) begin
      step(0, 1, vals[i], 0, 0);
      if (i == 1) check("plan_af_at_2", r_af, 1);
    end
    check("plan_full", r_full, 1);
    check("plan_count4", 32'(r_count), 4);
    step(0, 1, 8'h99, 0, 0);
    check("plan_ovf", r_ovf, 1);
    check("plan_count_hold", 32'(r_count), 4);

    // Drain with one-cycle rd_valid pulses, then underflow
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 1, 0);
      check("plan_pop_data", r_rd_data, vals[i]);
      check("plan_pop_valid", r_rd_valid, 1);
    end
    check("plan_empty", r_empty, 1);
    step(0, 0, 0, 1, 0);
    check("plan_udf", r_udf, 1);
    check("plan_udf_novalid", r_rd_valid, 0);
    step(0, 0, 0, 0, 1);
    check("plan_clr_udf", r_udf, 0);

    // FWFT fall-through
    step(0, 1, 8'hA5, 0, 0);
    check("fwft_valid", f_rd_valid, 1);
    check("fwft_data", f_rd_data, 8'hA5);
    step(0, 0, 0, 1, 0);
    check("fwft_pop_invalid", f_rd_valid, 0);

    // Steady push/pop at count 2 across pointer wrap
    step(0, 1, 8'hF0, 0, 0);
    step(0, 1, 8'hF1, 0, 0);
    for (int i = 0; i < 10; i++) begin
      step(0, 1, W'(i), 1, 0);
      check("pp_count", 32'(r_count), 2);
    end
    step(0, 0, 0, 1, 0);
    check("pp_order", r_rd_data, 8'h08);
    step(0, 0, 0, 1, 0);
    check("pp_order_last", r_rd_data, 8'h09);

    // Push+pop on a full FIFO
    for (int i = 0; i < 4; i++) step(0, 1, vals[i], 0, 0);
    step(0, 1, 8'h77, 1, 0);
    check("full_pp_data", r_rd_data, 8'h11);
    check("full_pp_count", 32'(r_count), 3);
    check("full_pp_ovf", r_ovf, 1);
    step(0, 0, 0, 0, 1);
    check("clr_ovf", r_ovf, 0);

    // Mid-operation reset discards contents
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, vals[i], 0, 0);
    step(1, 0, 0, 0, 0);
    check("rst_mid_count", 32'(r_count), 0);
    check("rst_mid_empty", r_empty, 1);
    step(0, 1, 8'h55, 0, 0);
    step(0, 0, 0, 1, 0);
    check("rst_mid_data", r_rd_data, 8'h55);

    // Randomised traffic
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(63) == 0), $urandom_range(1) == 1, W'($urandom),
           $urandom_range(1) == 1, ($urandom_range(7) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
